// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Status/Cause/EPC and exception arbitration
// Fixed-priority exceptions with branch-delay-aware EPC; services mtc0/mfc0/eret.
module cp0_exc_ctrl #(
   parameter int          NUM_IRQ    = 6,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
   parameter int          RESET_IM   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [31:0]        if_pc,
   input  logic [31:0]        id_pc,
   input  logic [31:0]        mem_pc,
   input  logic               id_bj,
   input  logic               mem_bj,
   input  logic               id_syscall,
   input  logic               id_unknown,
   input  logic               exe_overflow,
   input  logic               eret,
   input  logic               mtc0_we,
   input  logic [4:0]         cp0_waddr,
   input  logic [31:0]        cp0_wdata,
   input  logic [4:0]         cp0_raddr,
   output logic [31:0]        cp0_rdata,
   output logic               exc_taken,
   output logic [31:0]        exc_vector,
   output logic [31:0]        epc_out,
   output logic               exl
);

   localparam logic [7:0] RESET_IM_V = 8'(RESET_IM);

   logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
   logic               ie_q, ie_d;
   logic               exl_q, exl_d;
   logic [NUM_IRQ-1:0] im_q, im_d;
   logic [NUM_IRQ-1:0] ip_q, ip_d;
   logic [4:0]         exccode_q, exccode_d;
   logic               bd_q, bd_d;
   logic [31:0]        epc_q, epc_d;

   logic               int_req;
   logic               exc_any;
   logic [4:0]         exc_code;
   logic [31:0]        exc_epc;
   logic               exc_bd;
   logic               wr_status, wr_cause, wr_epc;
   logic [31:0]        status_v, cause_v;
   logic               unused_wdata;

   assign unused_wdata = ^cp0_wdata;

   assign wr_status = mtc0_we && (cp0_waddr == 5'd12);
   assign wr_cause  = mtc0_we && (cp0_waddr == 5'd13);
   assign wr_epc    = mtc0_we && (cp0_waddr == 5'd14);

   assign int_req = ie_q & ~exl_q & (|(ip_q & im_q));
   assign exc_any = exe_overflow | id_syscall | id_unknown | int_req;
   // Gated by rst so the redirect drops the instant reset asserts.
   assign exc_taken = ~rst & ~exl_q & exc_any;

   always_comb begin
      exc_code = 5'd0;
      exc_epc  = if_pc;
      exc_bd   = 1'b0;
      if (exe_overflow) begin
         exc_code = 5'd12;
         exc_epc  = mem_bj ? mem_pc : id_pc;
         exc_bd   = mem_bj;
      end else if (id_syscall) begin
         exc_code = 5'd8;
      end else if (id_unknown) begin
         exc_code = 5'd10;
      end else if (id_bj) begin
         exc_epc  = id_pc;
         exc_bd   = 1'b1;
      end
   end

   always_comb begin
      ie_d      = wr_status ? cp0_wdata[0] : ie_q;
      im_d      = wr_status ? cp0_wdata[8 +: NUM_IRQ] : im_q;
      // Software can only clear pending bits; a live synchronised request re-sets them.
      ip_d      = (wr_cause ? (ip_q & cp0_wdata[8 +: NUM_IRQ]) : ip_q) | irq_s2_q;
      exccode_d = exccode_q;
      bd_d      = bd_q;
      epc_d     = wr_epc ? cp0_wdata : epc_q;
      exl_d     = exl_q;
      if (exc_taken) begin
         exl_d     = 1'b1;
         epc_d     = exc_epc;
         exccode_d = exc_code;
         bd_d      = exc_bd;
      end else if (eret && exl_q) begin
         exl_d = 1'b0;
      end else if (wr_status) begin
         exl_d = cp0_wdata[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_s1_q  <= '0;
         irq_s2_q  <= '0;
         ie_q      <= 1'b0;
         exl_q     <= 1'b0;
         im_q      <= RESET_IM_V[NUM_IRQ-1:0];
         ip_q      <= '0;
         exccode_q <= 5'd0;
         bd_q      <= 1'b0;
         epc_q     <= 32'd0;
      end else begin
         irq_s1_q  <= irq;
         irq_s2_q  <= irq_s1_q;
         ie_q      <= ie_d;
         exl_q     <= exl_d;
         im_q      <= im_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         bd_q      <= bd_d;
         epc_q     <= epc_d;
      end
   end

   always_comb begin
      status_v               = 32'd0;
      status_v[0]            = ie_q;
      status_v[1]            = exl_q;
      status_v[8 +: NUM_IRQ] = im_q;
      cause_v                = 32'd0;
      cause_v[6:2]           = exccode_q;
      cause_v[8 +: NUM_IRQ]  = ip_q;
      cause_v[31]            = bd_q;
      case (cp0_raddr)
         5'd12:   cp0_rdata = status_v;
         5'd13:   cp0_rdata = cause_v;
         5'd14:   cp0_rdata = epc_q;
         default: cp0_rdata = 32'd0;
      endcase
   end

   assign exc_vector = EXC_VECTOR;
   assign epc_out    = epc_q;
   assign exl        = exl_q;

endmodule
